float_to_int: RTL

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/float_to_int_pkg.sv | 56 +++++
 rtl/float_to_int.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/float_to_int_pkg.sv
// -----------------------------------------------------------------------------
// float_to_int_pkg
//   Shared constants and types for the split-word IEEE-754 single-precision
//   blocks (adder, multiplier, float-to-int). Holds the format geometry, the
//   exponent bias, well-known encodings, the float_to_int state encoding and
//   the default result for unrepresentable conversions.
// -----------------------------------------------------------------------------
package float_to_int_pkg;

  // Format geometry shared by every float block.
  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int WORD_W  = 16;  // width of one half of the split-word bus

  // Exponent bias of the single-precision format.
  localparam logic [EXP_W-1:0] FLOAT_BIAS = 8'd127;

  // Well-known encodings used by the adder/multiplier special-case paths.
  localparam logic [FLOAT_W-1:0] FLOAT_QNAN    = 32'h7FC0_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_POS_INF = 32'h7F80_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_NEG_INF = 32'hFF80_0000;

  // Adder/multiplier internal datapath constants.
  localparam int ADD_GUARD_BITS  = 3;                // guard, round, sticky
  localparam int MULT_PRODUCT_W  = 2 * (MANT_W + 1); // full mantissa product
  localparam logic signed [9:0] EXP_DENORM_MIN = -10'sd126;

  // Integer result for NaN, infinities and magnitudes >= 2^31.
  localparam logic [FLOAT_W-1:0] F2I_OVERFLOW_DEFAULT = 32'h8000_0000;

  // Largest unbiased exponent that still fits a signed 32-bit integer
  // (excluding -2^31, which is reported through the overflow value).
  localparam logic signed [9:0] F2I_MAX_EXP = 10'sd30;

  // Exponent at which the mantissa register holds the integer part exactly.
  localparam logic signed [9:0] F2I_ALIGN_EXP = 10'sd31;

  typedef enum logic [2:0] {
    F2I_GET_A,
    F2I_GET_A_LO,
    F2I_UNPACK,
    F2I_SPECIAL_CASES,
    F2I_CONVERT,
    F2I_APPLY_SIGN,
    F2I_PUT_Z,
    F2I_PUT_Z_LO
  } f2i_state_e;

  // Remove the bias from an 8-bit exponent field, giving a 10-bit signed
  // value wide enough for both -127 and +128.
  function automatic logic signed [9:0] unbias_exp(input logic [EXP_W-1:0] biased);
    return $signed({2'b00, biased}) - $signed({2'b00, FLOAT_BIAS});
  endfunction

endpackage

// File: rtl/float_to_int.sv
// -----------------------------------------------------------------------------
// float_to_int
//   Converts an IEEE-754 single-precision value to a signed 32-bit integer,
//   truncating toward zero. Operands and results move as two 16-bit words
//   (high half first) over stb/ack handshakes that match the other float
//   blocks, so this stage chains directly after the multiplier output.
//
//   Ports
//     clk           single clock, rising-edge active
//     rst           asynchronous, active-low reset
//     input_a       operand word (high half, then low half)
//     input_a_stb   upstream word valid
//     input_a_ack   block ready for an operand word (registered)
//     output_z      result word (high half, then low half), held until taken
//     output_z_stb  result word valid (registered)
//     output_z_ack  downstream accepted the word
//
//   Parameter
//     OVERFLOW_VALUE  result for NaN, infinity and out-of-range magnitudes
// -----------------------------------------------------------------------------
module float_to_int
  import float_to_int_pkg::*;
#(
  parameter logic [31:0] OVERFLOW_VALUE = F2I_OVERFLOW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [15:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  f2i_state_e        state;
  logic [31:0]       a;          // captured operand
  logic [31:0]       m;          // mantissa, integer part ends up in m
  logic [31:0]       z;          // signed integer result
  logic signed [9:0] e;          // unbiased exponent, walks up to 31
  logic              s;          // operand sign
  logic              ack_armed;  // first cycle out of reset keeps ack low

  // Single sequential process: control, handshake and datapath all advance
  // together so every output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= F2I_GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      ack_armed    <= 1'b0;
      a            <= '0;
      m            <= '0;
      z            <= '0;
      e            <= '0;
      s            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; each register sees
      // the pre-edge values of the others, which the handshake relies on
      // (ack is tested and cleared in the same edge).
      case (state)
        F2I_GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a[31:16]    <= input_a;
            input_a_ack <= 1'b0;
            state       <= F2I_GET_A_LO;
          end else if (ack_armed) begin
            input_a_ack <= 1'b1;
          end else begin
            ack_armed <= 1'b1;
          end
        end

        F2I_GET_A_LO: begin
          if (input_a_ack && input_a_stb) begin
            a[15:0]     <= input_a;
            input_a_ack <= 1'b0;
            state       <= F2I_UNPACK;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        F2I_UNPACK: begin
          // Hidden one on top, fraction below it, eight zero pad bits so
          // that m read as an integer is the value scaled by 2^(31-e).
          m     <= {1'b1, a[22:0], 8'b0};
          e     <= unbias_exp(a[30:23]);
          s     <= a[31];
          state <= F2I_SPECIAL_CASES;
        end

        F2I_SPECIAL_CASES: begin
          // Signed compares: e < 0 covers zero, denormals and |x| < 1;
          // e > 30 covers NaN, infinities and |x| >= 2^31 (including -2^31,
          // whose encoding equals the overflow value anyway).
          if (e < 10'sd0) begin
            z     <= '0;
            state <= F2I_PUT_Z;
          end else if (e > F2I_MAX_EXP) begin
            z     <= OVERFLOW_VALUE;
            state <= F2I_PUT_Z;
          end else begin
            state <= F2I_CONVERT;
          end
        end

        F2I_CONVERT: begin
          // One right shift per cycle until the binary point sits just
          // below bit 0; shifted-out fraction bits are simply dropped,
          // which truncates toward zero on the magnitude.
          if (e == F2I_ALIGN_EXP) begin
            state <= F2I_APPLY_SIGN;
          end else begin
            m <= m >> 1;
            e <= e + 10'sd1;
          end
        end

        F2I_APPLY_SIGN: begin
          z     <= s ? (~m + 32'd1) : m;
          state <= F2I_PUT_Z;
        end

        F2I_PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z[31:16];
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= F2I_PUT_Z_LO;
          end
        end

        F2I_PUT_Z_LO: begin
          output_z_stb <= 1'b1;
          output_z     <= z[15:0];
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= F2I_GET_A;
          end
        end

        default: state <= F2I_GET_A;
      endcase
    end
  end

endmodule
